shift_arbiter: RTL and testbench

//  Shares one 7-stage pipelined 32-bit barrel shifter between two requesters.
//  - Round-robin grant, at most one issue per cycle.
//  - Tags each issued op with its requester ID and routes the result back on a matching delay line.
//  - Supports drain/idle so software can quiesce the shifter before reset or reconfiguration.

---
 rtl/shift_arbiter_pkg.sv | 18 +
 rtl/shift_tag_pipe.sv | 44 ++++
 rtl/shift_arbiter.sv | 129 ++++++++++++
 tb/tb_shift_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_arbiter_pkg.sv
// Shared constants and types for the two-requester barrel-shifter arbiter.
package shift_arbiter_pkg;

  localparam int WIDTH   = 32;                  // shifter data width
  localparam int SHW     = 5;                   // shift-amount width
  localparam int LATENCY = 7;                   // shifter stages, capture to registered output
  localparam int CNTW    = $clog2(LATENCY + 1); // wide enough to hold 0..LATENCY

  // Requester identifier: 0 or 1.
  typedef logic req_id_t;

  // One entry of the result-routing delay line.
  typedef struct packed {
    logic    vld;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/shift_tag_pipe.sv
// LATENCY-deep delay line of {vld, id} that tracks each op through the
// external shifter, so the result can be steered back to its requester.
module shift_tag_pipe
  import shift_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    reset,      // asynchronous, active-low
  input  logic    in_vld,
  input  req_id_t in_id,
  output logic    out_vld,
  output req_id_t out_id
);

  tag_t stage_reg [LATENCY];
  tag_t stage_next [LATENCY];

  // Each stage loads from its predecessor; stage 0 loads the op issued this cycle.
  generate
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stage_next[gi] = '{vld: in_vld, id: in_id};
      end else begin : g_body
        assign stage_next[gi] = stage_reg[gi-1];
      end
    end
  endgenerate

  // Shift every cycle; reset throws away every op still in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_reg[i] <= stage_next[i];
      end
    end
  end

  assign out_vld = stage_reg[LATENCY-1].vld;
  assign out_id  = stage_reg[LATENCY-1].id;

endmodule

// File: rtl/shift_arbiter.sv
// Shares one pipelined barrel shifter between two requesters: round-robin
// grant, one issue per cycle, results routed back through a matching tag pipe.
module shift_arbiter
  import shift_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,       // asynchronous, active-low
  // requester 0
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [SHW-1:0]   req0_amt,
  input  logic             req0_right,
  output logic             req0_ready,
  // requester 1
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [SHW-1:0]   req1_amt,
  input  logic             req1_right,
  output logic             req1_ready,
  // results
  output logic             res0_valid,
  output logic             res1_valid,
  output logic [WIDTH-1:0] res_data,
  // quiesce control
  input  logic             drain,
  output logic             idle,
  output logic [CNTW-1:0]  inflight,
  // external shifter
  output logic [WIDTH-1:0] sh_I,
  output logic [SHW-1:0]   sh_S,
  output logic             sh_R,
  output logic             sh_rst,
  input  logic [WIDTH-1:0] sh_O
);

  logic            ptr_reg, ptr_next;   // requester favoured when both are valid
  logic            grant0, grant1, grant;
  req_id_t         grant_id;
  logic [CNTW-1:0] inflight_reg, inflight_next;
  logic            res_vld;
  req_id_t         res_id;

  // Round-robin grant; reset is folded in so ready drops the moment reset asserts.
  always_comb begin
    grant0   = 1'b0;
    grant1   = 1'b0;
    if (reset && !drain) begin
      grant0 = req0_valid && (!req1_valid || (ptr_reg == 1'b0));
      grant1 = req1_valid && (!req0_valid || (ptr_reg == 1'b1));
    end
    grant    = grant0 | grant1;
    grant_id = grant1;
  end

  // Pointer flips to the other requester after any grant, holds otherwise.
  always_comb begin
    ptr_next = ptr_reg;
    if (grant0) begin
      ptr_next = 1'b1;
    end else if (grant1) begin
      ptr_next = 1'b0;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg <= 1'b0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  // Granted op goes straight to the shifter inputs; zero when nothing issues.
  always_comb begin
    sh_I = '0;
    sh_S = '0;
    sh_R = 1'b0;
    if (grant0) begin
      sh_I = req0_data;
      sh_S = req0_amt;
      sh_R = req0_right;
    end else if (grant1) begin
      sh_I = req1_data;
      sh_S = req1_amt;
      sh_R = req1_right;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign sh_rst     = ~reset;

  shift_tag_pipe u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (grant),
    .in_id   (grant_id),
    .out_vld (res_vld),
    .out_id  (res_id)
  );

  assign res0_valid = res_vld & (res_id == 1'b0);
  assign res1_valid = res_vld & (res_id == 1'b1);
  assign res_data   = sh_O;

  // Issue adds one, a returning result removes one; both together cancel.
  always_comb begin
    inflight_next = inflight_reg;
    if (grant && !res_vld) begin
      inflight_next = inflight_reg + 1'b1;
    end else if (!grant && res_vld) begin
      inflight_next = inflight_reg - 1'b1;
    end
  end

  // In-flight op counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_reg <= '0;
    end else begin
      inflight_reg <= inflight_next;
    end
  end

  assign inflight = inflight_reg;
  assign idle     = (inflight_reg == '0) && !grant;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with a behavioural 7-stage shifter model.
module tb_shift_arbiter;
  import shift_arbiter_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req0_right, req0_ready;
  logic [WIDTH-1:0] req0_data;
  logic [SHW-1:0]   req0_amt;
  logic             req1_valid, req1_right, req1_ready;
  logic [WIDTH-1:0] req1_data;
  logic [SHW-1:0]   req1_amt;
  logic             res0_valid, res1_valid;
  logic [WIDTH-1:0] res_data;
  logic             drain, idle;
  logic [CNTW-1:0]  inflight;
  logic [WIDTH-1:0] sh_I, sh_O;
  logic [SHW-1:0]   sh_S;
  logic             sh_R, sh_rst;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  shift_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req0_right (req0_right),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .req1_right (req1_right),
    .req1_ready (req1_ready),
    .res0_valid (res0_valid),
    .res1_valid (res1_valid),
    .res_data   (res_data),
    .drain      (drain),
    .idle       (idle),
    .inflight   (inflight),
    .sh_I       (sh_I),
    .sh_S       (sh_S),
    .sh_R       (sh_R),
    .sh_rst     (sh_rst),
    .sh_O       (sh_O)
  );

  // External shifter model: computes at capture, then delays to LATENCY stages.
  logic [WIDTH-1:0] sp [LATENCY];
  always_ff @(posedge clk or posedge sh_rst) begin
    if (sh_rst) begin
      for (int i = 0; i < LATENCY; i++) sp[i] <= '0;
    end else begin
      sp[0] <= sh_R ? (sh_I >> sh_S) : (sh_I << sh_S);
      for (int i = 1; i < LATENCY; i++) sp[i] <= sp[i-1];
    end
  end
  assign sh_O = sp[LATENCY-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs just after the falling edge, settle, then the caller samples.
  task automatic drive(input logic v0, input logic [31:0] d0, input logic [4:0] a0, input logic r0,
                       input logic v1, input logic [31:0] d1, input logic [4:0] a1, input logic r1,
                       input logic dr);
    @(negedge clk);
    req0_valid = v0; req0_data = d0; req0_amt = a0; req0_right = r0;
    req1_valid = v1; req1_data = d1; req1_amt = a1; req1_right = r1;
    drain = dr;
    #1;
  endtask

  task automatic quiet();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    quiet();
    while (!idle && n < max) begin
      quiet();
      n++;
    end
    chk(tag, 32'(idle), 32'h1);
  endtask

  initial begin
    int cnt;
    logic e0, e1;
    // ---------------- reset state ----------------
    reset = 1'b0; drain = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h1; req0_amt = 5'd1; req0_right = 1'b0;
    req1_valid = 1'b1; req1_data = 32'h1; req1_amt = 5'd1; req1_right = 1'b0;
    #2;
    chk("rst_ready0",   32'(req0_ready), 32'h0);
    chk("rst_ready1",   32'(req1_ready), 32'h0);
    chk("rst_res0v",    32'(res0_valid), 32'h0);
    chk("rst_res1v",    32'(res1_valid), 32'h0);
    chk("rst_inflight", 32'(inflight),   32'h0);
    chk("rst_idle",     32'(idle),       32'h1);
    chk("rst_sh_rst",   32'(sh_rst),     32'h1);
    repeat (2) @(negedge clk);
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("rel_sh_rst", 32'(sh_rst), 32'h0);

    // ---------------- single op: req0 1<<4 ----------------
    drive(1'b1, 32'h1, 5'd4, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("single_ready0", 32'(req0_ready), 32'h1);
    chk("single_ready1", 32'(req1_ready), 32'h0);
    chk("single_shI",    sh_I,            32'h1);
    chk("single_shS",    32'(sh_S),       32'h4);
    chk("single_shR",    32'(sh_R),       32'h0);
    chk("single_idle",   32'(idle),       32'h0);
    for (int c = 1; c <= 8; c++) begin
      quiet();
      if (c == 1) chk("single_inflight", 32'(inflight), 32'h1);
      chk("single_res0v", 32'(res0_valid), (c == 7) ? 32'h1 : 32'h0);
      chk("single_res1v", 32'(res1_valid), 32'h0);
      if (c == 7) chk("single_data", res_data, 32'h0000_0010);
    end
    chk("single_idle_end", 32'(idle), 32'h1);

    // ---------------- right shift: req1 0x8000_0000 >> 31 ----------------
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 32'h8000_0000, 5'd31, 1'b1, 1'b0);
    chk("right_ready1", 32'(req1_ready), 32'h1);
    chk("right_shR",    32'(sh_R),       32'h1);
    for (int c = 1; c <= 7; c++) begin
      quiet();
      chk("right_res1v", 32'(res1_valid), (c == 7) ? 32'h1 : 32'h0);
      chk("right_res0v", 32'(res0_valid), 32'h0);
      if (c == 7) chk("right_data", res_data, 32'h0000_0001);
    end
    wait_idle("right_idle", 4);

    // ---------------- contention: both valid 6 cycles ----------------
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 32'h1, 5'(k), 1'b0, 1'b1, 32'h8000_0000, 5'(k), 1'b1, 1'b0);
      chk("cont_ready0", 32'(req0_ready), (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("cont_ready1", 32'(req1_ready), (k % 2 == 1) ? 32'h1 : 32'h0);
    end
    for (int c = 6; c < 14; c++) begin
      quiet();
      if (c == 6) chk("cont_inflight_peak", 32'(inflight), 32'h6);
      e0 = (c >= 7) && (c <= 12) && ((c - 7) % 2 == 0);
      e1 = (c >= 7) && (c <= 12) && ((c - 7) % 2 == 1);
      chk("cont_res0v", 32'(res0_valid), 32'(e0));
      chk("cont_res1v", 32'(res1_valid), 32'(e1));
      if (e0) chk("cont_data0", res_data, 32'h1 << (c - 7));
      if (e1) chk("cont_data1", res_data, 32'h8000_0000 >> (c - 7));
    end
    chk("cont_idle_end", 32'(idle), 32'h1);

    // ---------------- back-to-back: req0 for 10 cycles ----------------
    for (int c = 0; c < 18; c++) begin
      if (c < 10) drive(1'b1, 32'h1, 5'(c), 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
      else        quiet();
      if (c < 10) chk("b2b_ready0", 32'(req0_ready), 32'h1);
      if (c >= 7 && c <= 9) chk("b2b_inflight", 32'(inflight), 32'h7);
      e0 = (c >= 7) && (c <= 16);
      chk("b2b_res0v", 32'(res0_valid), 32'(e0));
      if (e0) chk("b2b_data", res_data, 32'h1 << (c - 7));
    end
    chk("b2b_idle_end", 32'(idle), 32'h1);

    // ---------------- drain with 5 ops in flight ----------------
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 32'h3, 5'd1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    end
    cnt = 0;
    for (int c = 5; c < 15; c++) begin
      drive(1'b1, 32'h3, 5'd1, 1'b0, 1'b1, 32'h3, 5'd1, 1'b0, 1'b1);
      if (c == 5) begin
        chk("drain_inflight", 32'(inflight),   32'h5);
        chk("drain_ready0",   32'(req0_ready), 32'h0);
        chk("drain_ready1",   32'(req1_ready), 32'h0);
      end
      if (res0_valid) begin
        cnt++;
        chk("drain_data", res_data, 32'h6);
      end
      if (c == 12) chk("drain_idle_7", 32'(idle), 32'h1);
    end
    chk("drain_results", 32'(cnt), 32'h5);
    // Pointer was left on requester 1 by the last requester-0 grant.
    drive(1'b1, 32'h1, 5'd0, 1'b0, 1'b1, 32'h1, 5'd0, 1'b0, 1'b0);
    chk("resume_ready1", 32'(req1_ready), 32'h1);
    chk("resume_ready0", 32'(req0_ready), 32'h0);
    drive(1'b1, 32'h1, 5'd0, 1'b0, 1'b1, 32'h1, 5'd0, 1'b0, 1'b0);
    chk("resume2_ready0", 32'(req0_ready), 32'h1);
    wait_idle("resume_idle", 12);

    // ---------------- reset mid-flight with 4 ops ----------------
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 32'h1, 5'd2, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    end
    @(negedge clk);
    chk("mid_pre_inflight", 32'(inflight), 32'h4);
    reset = 1'b0; req1_valid = 1'b1;
    #1;
    chk("mid_ready0",   32'(req0_ready), 32'h0);
    chk("mid_ready1",   32'(req1_ready), 32'h0);
    chk("mid_inflight", 32'(inflight),   32'h0);
    chk("mid_idle",     32'(idle),       32'h1);
    chk("mid_sh_rst",   32'(sh_rst),     32'h1);
    repeat (2) @(negedge clk);
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      quiet();
      if (res0_valid || res1_valid) cnt++;
    end
    chk("mid_no_results", 32'(cnt), 32'h0);
    drive(1'b1, 32'h1, 5'd0, 1'b0, 1'b1, 32'h1, 5'd0, 1'b0, 1'b0);
    chk("mid_first_ready0", 32'(req0_ready), 32'h1);
    chk("mid_first_ready1", 32'(req1_ready), 32'h0);
    wait_idle("mid_idle_end", 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
